eth_mac_cfg_ctrl: RTL and testbench
===================================

Name: eth_mac_cfg_ctrl

Overview:
Configuration and mode-sequencing controller for the Ethernet MAC core. It owns the MAC register bank at config addresses 0x00–0x04 and serves register accesses over a single-outstanding request/response interface. Any change to speed or interface mode, and any soft reset, is sequenced safely: quiesce the datapath, pulse the MAC reset, apply the new mode, then settle. It also keeps the TX/RX frame statistics counters.

Parameters:
RST_CYCLES, 8, number of cycles mac_rst_n is held low (minimum 1).
SETTLE_CYCLES, 16, number of cycles to wait after reset release before enables are restored (minimum 1).
QUIESCE_TIMEOUT, 1024, maximum cycles to wait for the datapath to go idle before the reset is forced.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cfg_req_valid  in  1  request valid
cfg_req_ready  out  1  request accepted when valid and ready are both high
cfg_req_write  in  1  1 = write, 0 = read
cfg_req_addr  in  5  register address
cfg_req_wdata  in  32  write data
cfg_rsp_valid  out  1  one-cycle response pulse
cfg_rsp_rdata  out  32  read data (0 for writes)
cfg_rsp_err  out  1  access error
mac_tx_busy  in  1  TX datapath mid-frame
mac_rx_busy  in  1  RX datapath mid-frame
tx_frame_done  in  1  one-cycle pulse per transmitted frame
rx_frame_done  in  1  one-cycle pulse per received frame
mac_rst_n  out  1  MAC datapath reset, active-low
mac_tx_en  out  1  effective TX enable
mac_rx_en  out  1  effective RX enable
mac_promisc  out  1  promiscuous mode
mac_addr  out  48  station address
mac_speed  out  2  applied speed (00 = 10M, 01 = 100M, 10 = 1000M)
mac_if_mode  out  2  applied interface mode (00 = MII, 01 = GMII, 10 = RGMII, 11 = RMII)
cfg_busy  out  1  sequencer not in IDLE

Behaviour:
Reset values:
- Control bits 0.
- mac_addr = 0.
- Speed register = 2'b10, mode register = 2'b01.
- mac_rst_n = 0 while rst_n is low; it goes to 1 on the first clk edge after release.
- Counters 0, cfg_rsp_valid = 0, state = IDLE.

Register map:
- 0x00 CONTROL: bit0 tx_en, bit1 rx_en, bit2 promisc. bit3 is soft_reset: write-1 starts the sequence and reads back as 0.
- 0x01 ADDR_HI: [15:0] holds mac_addr[47:32]. Upper bits read 0.
- 0x02 ADDR_LO: [31:0] holds mac_addr[31:0].
- 0x03 SPEED_MODE: [1:0] speed, [3:2] if_mode.
  - A write with speed = 11 is rejected: err = 1, no register change.
  - A valid write with a value different from the applied value starts the sequence.
  - A write with the same value completes with no sequence.
- 0x04 STATS: read returns {rx_cnt[15:0], tx_cnt[15:0]} and clears both counters. A write gets err = 1.
- Any other address: err = 1, rdata = 0.

Request/response handshake:
- cfg_req_ready = (state == IDLE) and no response pending.
- An accepted request produces cfg_rsp_valid high for exactly one cycle on the next cycle. There is no response backpressure.
- Reads and writes performed while the sequencer is busy are not accepted.

Sequencer FSM:
- IDLE:
  - A triggering write → QUIESCE. The new speed/mode is latched into pending registers.
  - mac_tx_en and mac_rx_en follow the CONTROL bits.
- QUIESCE:
  - mac_tx_en = mac_rx_en = 0.
  - When mac_tx_busy and mac_rx_busy are both low, or QUIESCE_TIMEOUT cycles have elapsed → RESET.
- RESET:
  - mac_rst_n = 0 for RST_CYCLES cycles.
  - mac_speed and mac_if_mode load the pending values on entry to RESET.
- SETTLE: mac_rst_n = 1; wait SETTLE_CYCLES cycles → IDLE.
- On return to IDLE the enables are restored from CONTROL.
- cfg_busy = (state != IDLE).

Statistics counters:
- 16-bit, saturating at 0xFFFF.
- If a frame-done pulse coincides with the clearing STATS read, the read returns the pre-increment value and the counter becomes 1.
- Counters are not cleared by the sequencer.

Reset mid-operation: asserting rst_n low at any point returns the FSM to IDLE with all reset values applied immediately (asynchronous).

Test Plan:
1. Write 0x01 = 0x0000_1234, then 0x02 = 0x5678_9ABC → mac_addr = 0x1234_5678_9ABC. Reading back 0x01 returns 0x0000_1234 with err = 0, response one cycle after accept.
2. With CONTROL = 0x3 and mac_tx_busy held high 5 cycles, write 0x03 = 0x1 →
   - cfg_busy = 1; enables drop to 0 while busy is held.
   - RESET is entered 1 cycle after busy falls; mac_rst_n is low for 8 cycles and mac_speed = 01 / if_mode = 00 during it.
   - 16 settle cycles follow, then enables return to 1 and cfg_busy = 0.
3. With busy held high permanently, a soft reset (write 0x00 = 0x8) → the reset is forced after 1024 QUIESCE cycles. cfg_req_ready = 0 throughout.
4. Write 0x03 = 0x3 (speed 11) → err = 1, no sequence. Write 0x03 = 0x6 (matches reset value) → err = 0, cfg_busy stays 0.
5. 3 tx_frame_done and 2 rx_frame_done pulses, then a STATS read coinciding with a tx pulse → rdata = 0x0002_0003. A subsequent read returns 0x0000_0001.
6. 70000 tx pulses → tx_cnt saturates at 0xFFFF. Asserting rst_n low mid-QUIESCE → FSM returns to IDLE and all outputs take their reset values.

Source files
------------

// File: rtl/eth_mac_cfg_ctrl.sv
// Ethernet MAC configuration controller: register bank, mode-change/soft-reset
// sequencer (IDLE -> QUIESCE -> RESET -> SETTLE -> IDLE) and frame statistics.
module eth_mac_cfg_ctrl #(
  parameter int RST_CYCLES      = 8,
  parameter int SETTLE_CYCLES   = 16,
  parameter int QUIESCE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req_valid,
  output logic        cfg_req_ready,
  input  logic        cfg_req_write,
  input  logic [4:0]  cfg_req_addr,
  input  logic [31:0] cfg_req_wdata,
  output logic        cfg_rsp_valid,
  output logic [31:0] cfg_rsp_rdata,
  output logic        cfg_rsp_err,
  input  logic        mac_tx_busy,
  input  logic        mac_rx_busy,
  input  logic        tx_frame_done,
  input  logic        rx_frame_done,
  output logic        mac_rst_n,
  output logic        mac_tx_en,
  output logic        mac_rx_en,
  output logic        mac_promisc,
  output logic [47:0] mac_addr,
  output logic [1:0]  mac_speed,
  output logic [1:0]  mac_if_mode,
  output logic        cfg_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUIESCE = 2'd1;
  localparam logic [1:0] ST_RESET   = 2'd2;
  localparam logic [1:0] ST_SETTLE  = 2'd3;

  logic [1:0]  state;
  logic [31:0] cnt;
  logic        ctrl_tx_en;
  logic        ctrl_rx_en;
  logic [1:0]  spd_reg;
  logic [1:0]  mode_reg;
  logic [15:0] tx_cnt;
  logic [15:0] rx_cnt;
  logic        accept;
  logic        start_seq;
  logic        stats_clr;
  logic [31:0] rdata_d;
  logic        err_d;

  // Handshake: a request is taken on a clock edge where valid && ready;
  // its response is a single-cycle pulse on the following cycle, and ready
  // stays low while that pulse is pending or the sequencer is active.
  assign cfg_req_ready = (state == ST_IDLE) && !cfg_rsp_valid;
  assign accept        = cfg_req_valid && cfg_req_ready;
  assign cfg_busy      = (state != ST_IDLE);
  assign mac_tx_en     = (state == ST_IDLE) && ctrl_tx_en;
  assign mac_rx_en     = (state == ST_IDLE) && ctrl_rx_en;

  always_comb begin
    rdata_d   = '0;
    err_d     = 1'b0;
    start_seq = 1'b0;
    stats_clr = 1'b0;
    case (cfg_req_addr)
      5'h00: begin
        if (cfg_req_write) start_seq = cfg_req_wdata[3];
        else rdata_d = {29'd0, mac_promisc, ctrl_rx_en, ctrl_tx_en};
      end
      5'h01: if (!cfg_req_write) rdata_d = {16'd0, mac_addr[47:32]};
      5'h02: if (!cfg_req_write) rdata_d = mac_addr[31:0];
      5'h03: begin
        if (cfg_req_write) begin
          if (cfg_req_wdata[1:0] == 2'b11) err_d = 1'b1;
          else start_seq = (cfg_req_wdata[3:0] != {mac_if_mode, mac_speed});
        end else begin
          rdata_d = {28'd0, mode_reg, spd_reg};
        end
      end
      5'h04: begin
        if (cfg_req_write) err_d = 1'b1;
        else begin
          rdata_d   = {rx_cnt, tx_cnt};
          stats_clr = 1'b1;
        end
      end
      default: err_d = 1'b1;
    endcase
    if (!accept) begin
      start_seq = 1'b0;
      stats_clr = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rsp_valid <= 1'b0;
      cfg_rsp_rdata <= '0;
      cfg_rsp_err   <= 1'b0;
      ctrl_tx_en    <= 1'b0;
      ctrl_rx_en    <= 1'b0;
      mac_promisc   <= 1'b0;
      mac_addr      <= '0;
      spd_reg       <= 2'b10;
      mode_reg      <= 2'b01;
    end else begin
      cfg_rsp_valid <= accept;
      if (accept) begin
        cfg_rsp_rdata <= cfg_req_write ? 32'd0 : rdata_d;
        cfg_rsp_err   <= err_d;
      end
      if (accept && cfg_req_write && !err_d) begin
        case (cfg_req_addr)
          5'h00: begin
            ctrl_tx_en  <= cfg_req_wdata[0];
            ctrl_rx_en  <= cfg_req_wdata[1];
            mac_promisc <= cfg_req_wdata[2];
          end
          5'h01: mac_addr[47:32] <= cfg_req_wdata[15:0];
          5'h02: mac_addr[31:0]  <= cfg_req_wdata;
          5'h03: begin
            spd_reg  <= cfg_req_wdata[1:0];
            mode_reg <= cfg_req_wdata[3:2];
          end
          default: ;
        endcase
      end
    end
  end

  // The speed/mode registers cannot change while busy, so they act as the
  // pending values and are applied on the QUIESCE -> RESET transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mac_rst_n   <= 1'b0;
      mac_speed   <= 2'b10;
      mac_if_mode <= 2'b01;
    end else begin
      case (state)
        ST_IDLE: begin
          mac_rst_n <= 1'b1;
          cnt       <= '0;
          if (start_seq) state <= ST_QUIESCE;
        end
        ST_QUIESCE: begin
          if ((!mac_tx_busy && !mac_rx_busy) ||
              (cnt == 32'(QUIESCE_TIMEOUT - 1))) begin
            state       <= ST_RESET;
            cnt         <= '0;
            mac_rst_n   <= 1'b0;
            mac_speed   <= spd_reg;
            mac_if_mode <= mode_reg;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_RESET: begin
          if (cnt == 32'(RST_CYCLES - 1)) begin
            state     <= ST_SETTLE;
            cnt       <= '0;
            mac_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          if (cnt == 32'(SETTLE_CYCLES - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
      endcase
    end
  end

  // A frame that completes on the clearing read edge is kept as a count of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (stats_clr) tx_cnt <= {15'd0, tx_frame_done};
      else if (tx_frame_done && tx_cnt != 16'hFFFF) tx_cnt <= tx_cnt + 16'd1;
      if (stats_clr) rx_cnt <= {15'd0, rx_frame_done};
      else if (rx_frame_done && rx_cnt != 16'hFFFF) rx_cnt <= rx_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_mac_cfg_ctrl.sv
// Directed testbench for eth_mac_cfg_ctrl: register access, sequencer timing,
// quiesce timeout, error cases, statistics and asynchronous reset.
module tb_eth_mac_cfg_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_req_valid;
  logic        cfg_req_ready;
  logic        cfg_req_write;
  logic [4:0]  cfg_req_addr;
  logic [31:0] cfg_req_wdata;
  logic        cfg_rsp_valid;
  logic [31:0] cfg_rsp_rdata;
  logic        cfg_rsp_err;
  logic        mac_tx_busy;
  logic        mac_rx_busy;
  logic        tx_frame_done;
  logic        rx_frame_done;
  logic        mac_rst_n;
  logic        mac_tx_en;
  logic        mac_rx_en;
  logic        mac_promisc;
  logic [47:0] mac_addr;
  logic [1:0]  mac_speed;
  logic [1:0]  mac_if_mode;
  logic        cfg_busy;

  int n_assert = 0;
  int n_fail   = 0;

  eth_mac_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready),
    .cfg_req_write(cfg_req_write), .cfg_req_addr(cfg_req_addr),
    .cfg_req_wdata(cfg_req_wdata), .cfg_rsp_valid(cfg_rsp_valid),
    .cfg_rsp_rdata(cfg_rsp_rdata), .cfg_rsp_err(cfg_rsp_err),
    .mac_tx_busy(mac_tx_busy), .mac_rx_busy(mac_rx_busy),
    .tx_frame_done(tx_frame_done), .rx_frame_done(rx_frame_done),
    .mac_rst_n(mac_rst_n), .mac_tx_en(mac_tx_en), .mac_rx_en(mac_rx_en),
    .mac_promisc(mac_promisc), .mac_addr(mac_addr), .mac_speed(mac_speed),
    .mac_if_mode(mac_if_mode), .cfg_busy(cfg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request starting at a negedge; returns at the negedge where the
  // response pulse is visible. with_tx raises tx_frame_done on the accept edge.
  task automatic cfg_access(input logic w, input logic [4:0] a, input logic [31:0] d,
                            input logic with_tx, output logic [31:0] rd, output logic e);
    int n;
    n = 0;
    @(negedge clk);
    cfg_req_valid = 1'b1;
    cfg_req_write = w;
    cfg_req_addr  = a;
    cfg_req_wdata = d;
    while (!cfg_req_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_timeout", 64'(n < 4000), 64'd1);
    tx_frame_done = with_tx;
    @(posedge clk);
    @(negedge clk);
    cfg_req_valid = 1'b0;
    tx_frame_done = 1'b0;
    chk("rsp_valid", 64'(cfg_rsp_valid), 64'd1);
    rd = cfg_rsp_rdata;
    e  = cfg_rsp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          n;
  logic        saw_ready;

  initial begin
    rst_n = 1'b0;
    cfg_req_valid = 1'b0; cfg_req_write = 1'b0; cfg_req_addr = '0; cfg_req_wdata = '0;
    mac_tx_busy = 1'b0; mac_rx_busy = 1'b0; tx_frame_done = 1'b0; rx_frame_done = 1'b0;
    #12;
    chk("rst_mac_rst_n", 64'(mac_rst_n), 64'd0);
    chk("rst_speed_mode", 64'({mac_if_mode, mac_speed}), 64'h6);
    chk("rst_busy_rsp", 64'({cfg_busy, cfg_rsp_valid, mac_tx_en, mac_rx_en, mac_promisc}), 64'd0);
    chk("rst_addr", 64'(mac_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_mac_rst_n", 64'(mac_rst_n), 64'd1);

    // Station address write/readback
    cfg_access(1'b1, 5'h01, 32'h0000_1234, 1'b0, rd, er);
    cfg_access(1'b1, 5'h02, 32'h5678_9ABC, 1'b0, rd, er);
    chk("mac_addr", 64'(mac_addr), 64'h1234_5678_9ABC);
    cfg_access(1'b0, 5'h01, 32'h0, 1'b0, rd, er);
    chk("addr_hi_rdata", 64'(rd), 64'h0000_1234);
    chk("addr_hi_err", 64'(er), 64'd0);
    @(negedge clk);
    chk("rsp_one_cycle", 64'(cfg_rsp_valid), 64'd0);

    // Error cases and same-value speed/mode write
    cfg_access(1'b1, 5'h03, 32'h3, 1'b0, rd, er);
    chk("speed11_err", 64'(er), 64'd1);
    chk("speed11_nobusy", 64'(cfg_busy), 64'd0);
    cfg_access(1'b0, 5'h03, 32'h0, 1'b0, rd, er);
    chk("speed11_unchanged", 64'(rd), 64'h6);
    cfg_access(1'b1, 5'h03, 32'h6, 1'b0, rd, er);
    chk("same_mode_err", 64'(er), 64'd0);
    chk("same_mode_nobusy", 64'(cfg_busy), 64'd0);
    @(negedge clk);
    chk("same_mode_nobusy_later", 64'(cfg_busy), 64'd0);
    cfg_access(1'b0, 5'h07, 32'h0, 1'b0, rd, er);
    chk("bad_addr", 64'({er, rd}), 64'h1_0000_0000);
    cfg_access(1'b1, 5'h04, 32'h0, 1'b0, rd, er);
    chk("stats_write_err", 64'(er), 64'd1);

    // Mode change sequence with TX busy held
    cfg_access(1'b1, 5'h00, 32'h3, 1'b0, rd, er);
    chk("enables_on", 64'({mac_tx_en, mac_rx_en, cfg_busy}), 64'b110);
    mac_tx_busy = 1'b1;
    cfg_access(1'b1, 5'h03, 32'h1, 1'b0, rd, er);
    chk("seq_busy", 64'(cfg_busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("quiesce_enables_off", 64'({mac_tx_en, mac_rx_en, mac_rst_n}), 64'b001);
      @(negedge clk);
    end
    chk("quiesce_speed_unapplied", 64'(mac_speed), 64'b10);
    mac_tx_busy = 1'b0;
    @(negedge clk);
    chk("reset_entered", 64'(mac_rst_n), 64'd0);
    chk("reset_speed_mode", 64'({mac_if_mode, mac_speed}), 64'h1);
    chk("reset_enables_off", 64'({mac_tx_en, mac_rx_en}), 64'd0);
    n = 0;
    while (mac_rst_n == 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("rst_low_cycles", 64'(n), 64'd8);
    n = 0;
    while (cfg_busy && n < 100) begin
      chk("settle_enables_off", 64'({mac_tx_en, mac_rx_en}), 64'd0);
      n++;
      @(negedge clk);
    end
    chk("settle_cycles", 64'(n), 64'd16);
    chk("enables_restored", 64'({mac_tx_en, mac_rx_en, cfg_busy}), 64'b110);
    cfg_access(1'b0, 5'h03, 32'h0, 1'b0, rd, er);
    chk("speed_mode_rd", 64'(rd), 64'h1);

    // Soft reset with datapath permanently busy: quiesce timeout
    mac_tx_busy = 1'b1;
    mac_rx_busy = 1'b1;
    cfg_access(1'b1, 5'h00, 32'h8, 1'b0, rd, er);
    n = 0;
    saw_ready = 1'b0;
    while (cfg_busy && mac_rst_n && n < 2000) begin
      if (cfg_req_ready) saw_ready = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("quiesce_timeout_cycles", 64'(n), 64'd1024);
    chk("quiesce_ready_low", 64'(saw_ready), 64'd0);
    chk("forced_reset", 64'(mac_rst_n), 64'd0);
    mac_tx_busy = 1'b0;
    mac_rx_busy = 1'b0;
    n = 0;
    while (cfg_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("soft_reset_done", 64'({cfg_busy, mac_tx_en, mac_rx_en, mac_rst_n}), 64'b0001);
    cfg_access(1'b0, 5'h00, 32'h0, 1'b0, rd, er);
    chk("ctrl_soft_bit_reads0", 64'(rd), 64'h0);

    // Statistics counters
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tx_frame_done = 1'b1;
      @(negedge clk); tx_frame_done = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rx_frame_done = 1'b1;
      @(negedge clk); rx_frame_done = 1'b0;
    end
    cfg_access(1'b0, 5'h04, 32'h0, 1'b1, rd, er);
    chk("stats_rd", 64'({er, rd}), 64'h0_0002_0003);
    cfg_access(1'b0, 5'h04, 32'h0, 1'b0, rd, er);
    chk("stats_after_clear", 64'(rd), 64'h0000_0001);
    @(negedge clk);
    tx_frame_done = 1'b1;
    repeat (70000) @(negedge clk);
    tx_frame_done = 1'b0;
    cfg_access(1'b0, 5'h04, 32'h0, 1'b0, rd, er);
    chk("stats_saturate", 64'(rd), 64'h0000_FFFF);

    // Asynchronous reset during QUIESCE
    mac_tx_busy = 1'b1;
    cfg_access(1'b1, 5'h00, 32'hF, 1'b0, rd, er);
    repeat (3) @(negedge clk);
    chk("midq_busy", 64'({cfg_busy, mac_promisc, mac_rst_n}), 64'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(cfg_busy), 64'd0);
    chk("async_outputs", 64'({mac_rst_n, mac_tx_en, mac_rx_en, mac_promisc, cfg_rsp_valid}), 64'd0);
    chk("async_addr", 64'(mac_addr), 64'd0);
    chk("async_speed_mode", 64'({mac_if_mode, mac_speed}), 64'h6);
    mac_tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_mac_rst_n", 64'({mac_rst_n, cfg_busy}), 64'b10);
    cfg_access(1'b0, 5'h00, 32'h0, 1'b0, rd, er);
    chk("post_reset_ctrl", 64'(rd), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
